alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LAST_VALID_CODOP, 10, highest codop the shared ALU implements; codops above it are rejected.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle when valid&&ready.
REQ-006 req0_codop / req1_codop  input  4 each  ALU operation code.
REQ-007 req0_op1, req0_op2, req1_op1, req1_op2  input  16 each  operands.
REQ-008 alu_codop  output  4  codop driven to the shared ALU.
REQ-009 alu_op1, alu_op2  output  16 each  operands driven to the shared ALU.
REQ-010 alu_resultado  input  16  registered ALU result, valid one cycle after issue.
REQ-011 alu_neg, alu_overflow  input  1 each  registered ALU flags.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes response when rsp_valid&&rsp_ready.
REQ-014 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-015 rsp_resultado  output  16  result; rsp_neg, rsp_overflow output 1 each flags; rsp_err output 1 rejected codop.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; exactly one operation in flight.
REQ-017 IDLE: ready asserted combinationally only to the granted requester; all readys low in other states.
REQ-018 Grant: single valid requester wins; both valid -> requester other than last_grant wins (round-robin).
REQ-019 Accept (valid&&ready in IDLE): latch codop, op1, op2, id; update last_grant to id.
REQ-020 Accepted codop <= LAST_VALID_CODOP -> next state ISSUE; codop > LAST_VALID_CODOP -> next state RESP with rsp_err=1, rsp_resultado=0, flags 0, ALU not issued.
REQ-021 ISSUE (1 cycle): alu_codop/op1/op2 driven from latched values; ALU samples at end of cycle; next state CAPTURE.
REQ-022 CAPTURE (1 cycle): latch alu_resultado into rsp_resultado; next state RESP.
REQ-023 rsp_neg/rsp_overflow SHALL equal alu_neg/alu_overflow for codops 0, 1, 9, 10 and 0 for all other codops (ALU leaves flags stale otherwise).
REQ-024 RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready; then next state IDLE.
REQ-025 Latency: accept cycle T -> rsp_valid first high at T+3 for valid codop, T+1 for rejected codop.
REQ-026 Minimum spacing between accepts: 4 cycles (valid codop, rsp_ready held high).
REQ-027 alu_codop/alu_op1/alu_op2 SHALL hold latched values outside ISSUE (no toggling when idle).
REQ-028 Requester inputs changing while not accepted SHALL not affect in-flight operation.

Reset
REQ-029 rst high at any clock edge, including mid-operation: state=IDLE, rsp_valid=0, rsp_id=0, rsp_resultado=0, rsp_neg=0, rsp_overflow=0, rsp_err=0, alu_codop=0, alu_op1=0, alu_op2=0, last_grant=1 (req0 wins first tie).
REQ-030 In-flight operation aborted by reset SHALL produce no response; next accept allowed in first cycle after rst deasserts.

Structure
REQ-031 Shared package: FSM state enum, codop constants (ADD=0, SUB=1, ..., ADDI=9, SUBI=10), flag-producing-codop predicate.
REQ-032 One sub-module natural: rr_arb2 (2-way round-robin grant with last_grant register).

Verification
REQ-033 req0 ADD 16'h7FFF+16'h0001, rsp_ready=1 -> rsp at accept+3: id=0, resultado=16'h8000, neg=1, overflow=1, err=0.
REQ-034 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted next IDLE; three back-to-back ties alternate 0,1,0.
REQ-035 req1 codop 2 (compare) 5>3 after prior overflowing ADD -> resultado=1, neg=0, overflow=0.
REQ-036 req0 codop 12 -> rsp at accept+1 with err=1, resultado=0; ALU inputs unchanged.
REQ-037 rsp_ready low 5 cycles during RESP -> rsp fields stable, both readys low, no new accept until handshake.
REQ-038 rst asserted in CAPTURE -> next cycle rsp_valid=0, state IDLE, no stale response emitted later.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter: FSM states,
// ALU operation codes and the predicate telling which codops refresh ALU flags.
package alu_arbiter_pkg;

  localparam int CODOP_W = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [CODOP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [CODOP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [CODOP_W-1:0] OP_CMP  = 4'd2;
  localparam logic [CODOP_W-1:0] OP_AND  = 4'd3;
  localparam logic [CODOP_W-1:0] OP_OR   = 4'd4;
  localparam logic [CODOP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [CODOP_W-1:0] OP_NOT  = 4'd6;
  localparam logic [CODOP_W-1:0] OP_SHL  = 4'd7;
  localparam logic [CODOP_W-1:0] OP_SHR  = 4'd8;
  localparam logic [CODOP_W-1:0] OP_ADDI = 4'd9;
  localparam logic [CODOP_W-1:0] OP_SUBI = 4'd10;

  // Only the arithmetic codops update neg/overflow; the ALU leaves them stale otherwise.
  function automatic logic codop_sets_flags(input logic [CODOP_W-1:0] codop);
    return (codop == OP_ADD) || (codop == OP_SUB) ||
           (codop == OP_ADDI) || (codop == OP_SUBI);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester that was not granted last wins. last_grant resets to 1 so req0 wins the first tie.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       gnt_id_o,
  output logic       last_grant_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_id_o = 1'b0;
    grant_o  = 2'b00;
    last_d   = last_q;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
    // A grant is an accept: ready is only shown to a requester that is valid.
    if (en_i && (req_i != 2'b00)) begin
      grant_o = gnt_id_o ? 2'b10 : 2'b01;
      last_d  = gnt_id_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant_o = last_q;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one registered ALU, one operation in flight,
// and returns the result on a response channel tagged with the owner id.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int LAST_VALID_CODOP = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_codop,
  input  logic [15:0]  req0_op1,
  input  logic [15:0]  req0_op2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_codop,
  input  logic [15:0]  req1_op1,
  input  logic [15:0]  req1_op2,
  output logic [3:0]   alu_codop,
  output logic [15:0]  alu_op1,
  output logic [15:0]  alu_op2,
  input  logic [15:0]  alu_resultado,
  input  logic         alu_neg,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [15:0]  rsp_resultado,
  output logic         rsp_neg,
  output logic         rsp_overflow,
  output logic         rsp_err,
  output state_e       dbg_state_o,
  output logic         dbg_last_grant_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on anything but state and the valids, and
  // a presented response holds every field stable until it transfers.

  state_e              state_q, state_d;
  logic [1:0]          grant;
  logic                gnt_id;
  logic                accept;
  logic                codop_ok;
  logic [CODOP_W-1:0]  sel_codop;
  logic [DATA_W-1:0]   sel_op1, sel_op2;

  logic [CODOP_W-1:0]  codop_q, codop_d;
  logic [CODOP_W-1:0]  alu_codop_q, alu_codop_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_res_q, rsp_res_d;
  logic                rsp_neg_q, rsp_neg_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                rsp_err_q, rsp_err_d;

  rr_arb2 u_arb (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        ({req1_valid, req0_valid}),
    .en_i         (state_q == ST_IDLE),
    .grant_o      (grant),
    .gnt_id_o     (gnt_id),
    .last_grant_o (dbg_last_grant_o)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign sel_codop = gnt_id ? req1_codop : req0_codop;
  assign sel_op1   = gnt_id ? req1_op1   : req0_op1;
  assign sel_op2   = gnt_id ? req1_op2   : req0_op2;
  assign codop_ok  = (32'(sel_codop) <= LAST_VALID_CODOP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = codop_ok ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ALU operand registers double as the operation latch, so they only move on a
  // valid accept and hold steady through idle and rejected operations.
  always_comb begin
    codop_d     = codop_q;
    alu_codop_d = alu_codop_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      codop_d  = sel_codop;
      rsp_id_d = gnt_id;
      if (codop_ok) begin
        alu_codop_d = sel_codop;
        alu_op1_d   = sel_op1;
        alu_op2_d   = sel_op2;
        rsp_err_d   = 1'b0;
      end else begin
        rsp_err_d = 1'b1;
        rsp_res_d = '0;
        rsp_neg_d = 1'b0;
        rsp_ovf_d = 1'b0;
      end
    end
    if (state_q == ST_CAPTURE) begin
      rsp_res_d = alu_resultado;
      rsp_neg_d = codop_sets_flags(codop_q) && alu_neg;
      rsp_ovf_d = codop_sets_flags(codop_q) && alu_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      codop_q     <= '0;
      alu_codop_q <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_neg_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      codop_q     <= codop_d;
      alu_codop_q <= alu_codop_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_codop     = alu_codop_q;
  assign alu_op1       = alu_op1_q;
  assign alu_op2       = alu_op2_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = rsp_id_q;
  assign rsp_resultado = rsp_res_q;
  assign rsp_neg       = rsp_neg_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_err       = rsp_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a registered ALU model sits behind the DUT,
// and each step checks hand-computed results, latency, grants and reset behaviour.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_codop, req1_codop, alu_codop;
  logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [15:0] alu_op1, alu_op2, alu_resultado;
  logic        alu_neg, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_neg, rsp_overflow, rsp_err;
  logic [15:0] rsp_resultado;
  state_e      dbg_state;
  logic        dbg_last_grant;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.LAST_VALID_CODOP(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_codop(req0_codop),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_codop(req1_codop),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_codop(alu_codop), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_resultado(alu_resultado), .alu_neg(alu_neg), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_resultado(rsp_resultado), .rsp_neg(rsp_neg), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .dbg_state_o(dbg_state), .dbg_last_grant_o(dbg_last_grant)
  );

  // Registered ALU: flags refresh only on add/sub style codops.
  logic [15:0] add_s, sub_s;
  assign add_s = alu_op1 + alu_op2;
  assign sub_s = alu_op1 - alu_op2;
  always @(posedge clk) begin
    case (alu_codop)
      4'd0, 4'd9: begin
        alu_resultado <= add_s;
        alu_neg       <= add_s[15];
        alu_overflow  <= (alu_op1[15] == alu_op2[15]) && (add_s[15] != alu_op1[15]);
      end
      4'd1, 4'd10: begin
        alu_resultado <= sub_s;
        alu_neg       <= sub_s[15];
        alu_overflow  <= (alu_op1[15] != alu_op2[15]) && (sub_s[15] != alu_op1[15]);
      end
      4'd2:    alu_resultado <= ($signed(alu_op1) > $signed(alu_op2)) ? 16'd1 : 16'd0;
      default: alu_resultado <= alu_op1 & alu_op2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic id, input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_codop = c; req1_op1 = a; req1_op2 = b;
    end else begin
      req0_valid = 1'b1; req0_codop = c; req0_op1 = a; req0_op2 = b;
    end
  endtask

  task automatic drop();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Check the ready pattern mid-cycle, then let the accept edge pass.
  task automatic accept_one(input string tag, input logic exp_id);
    @(negedge clk);
    check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
    tick();
  endtask

  // Called one cycle after the accept edge; counts cycles until rsp_valid.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [15:0] res,
                           input logic neg, input logic ovf, input logic err);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_id"},    {31'd0, rsp_id}, {31'd0, id});
    check({tag, "_res"},   {16'd0, rsp_resultado}, {16'd0, res});
    check({tag, "_neg"},   {31'd0, rsp_neg}, {31'd0, neg});
    check({tag, "_ovf"},   {31'd0, rsp_overflow}, {31'd0, ovf});
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, err});
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_codop = '0; req0_op1 = '0; req0_op2 = '0;
    req1_valid = 1'b0; req1_codop = '0; req1_op1 = '0; req1_op2 = '0;
    tick();
    tick();

    // Reset state
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_id", {31'd0, rsp_id}, 32'd0);
    check("rst_res", {16'd0, rsp_resultado}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_alu", {alu_codop, alu_op1, 12'd0}, 32'd0);
    check("rst_alu2", {16'd0, alu_op2}, 32'd0);
    check("rst_lastg", {31'd0, dbg_last_grant}, 32'd1);
    check("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    rst = 1'b0;

    // Overflowing ADD from req0
    present(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    accept_one("add", 1'b0);
    drop();
    check("add_issue", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
    check("add_alu_op", {alu_codop, 12'd0, alu_op1}, {4'd0, 12'd0, 16'h7FFF});
    check("add_alu_op2", {16'd0, alu_op2}, 32'd1);
    wait_rsp("add", 3);
    check_rsp("add", 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    tick();
    check("add_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // Ties after reset alternate 0,1,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tie_lastg", {31'd0, dbg_last_grant}, 32'd1);
    present(1'b0, 4'd0, 16'd1, 16'd2);
    present(1'b1, 4'd0, 16'd10, 16'd20);
    for (int i = 0; i < 3; i++) begin
      accept_one("tie", i[0]);
      @(negedge clk);
      check("tie_busy_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      wait_rsp("tie", 3);
      check_rsp("tie", i[0], i[0] ? 16'd30 : 16'd3, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drop();

    // Overflowing ADD, then CMP must not inherit the stale flags
    present(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    accept_one("add2", 1'b0);
    drop();
    wait_rsp("add2", 3);
    check_rsp("add2", 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    tick();
    present(1'b1, 4'd2, 16'd5, 16'd3);
    accept_one("cmp", 1'b1);
    drop();
    wait_rsp("cmp", 3);
    check_rsp("cmp", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    tick();

    // ADDI 0x8000+0x8000 wraps to zero with overflow
    present(1'b0, 4'd9, 16'h8000, 16'h8000);
    accept_one("addi", 1'b0);
    drop();
    wait_rsp("addi", 3);
    check_rsp("addi", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();

    // Rejected codop: fast error response, ALU inputs untouched
    present(1'b0, 4'd12, 16'h1234, 16'h5678);
    accept_one("rej", 1'b0);
    drop();
    wait_rsp("rej", 1);
    check_rsp("rej", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("rej_alu", {alu_codop, 12'd0, alu_op1}, {4'd9, 12'd0, 16'h8000});
    check("rej_alu2", {16'd0, alu_op2}, 32'h8000);
    tick();

    // Consumer stalls 5 cycles; requester inputs change while in flight
    rsp_ready = 1'b0;
    present(1'b1, 4'd1, 16'd10, 16'd3);
    accept_one("stall", 1'b1);
    drop();
    req1_op1 = 16'd999; req1_codop = 4'd0;
    present(1'b0, 4'd0, 16'd1, 16'd1);
    wait_rsp("stall", 3);
    for (int k = 0; k < 5; k++) begin
      check("stall_res", {15'd0, rsp_valid, rsp_resultado}, {15'd0, 1'b1, 16'd7});
      check("stall_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    check_rsp("stall", 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
    tick();
    accept_one("after_stall", 1'b0);
    drop();
    wait_rsp("after_stall", 3);
    check_rsp("after_stall", 1'b0, 16'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset during CAPTURE aborts the operation
    present(1'b0, 4'd0, 16'd100, 16'd200);
    accept_one("abort", 1'b0);
    drop();
    tick();
    check("abort_capture", {30'd0, dbg_state}, {30'd0, ST_CAPTURE});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_res", {16'd0, rsp_resultado}, 32'd0);
    check("abort_alu", {alu_codop, 12'd0, alu_op1}, 32'd0);
    check("abort_lastg", {31'd0, dbg_last_grant}, 32'd1);
    present(1'b0, 4'd1, 16'd50, 16'd20);
    present(1'b1, 4'd0, 16'd3, 16'd4);
    accept_one("post_rst", 1'b0);
    drop();
    wait_rsp("post_rst", 3);
    check_rsp("post_rst", 1'b0, 16'd30, 1'b0, 1'b0, 1'b0);
    tick();

    // ALU inputs hold while idle
    tick();
    tick();
    check("idle_hold", {alu_codop, 12'd0, alu_op1}, {4'd1, 12'd0, 16'd50});
    check("idle_hold2", {16'd0, alu_op2}, 32'd20);
    check("idle_valid", {31'd0, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
